// File: rtl/pb_exec_ctrl_if.sv
// Issue / processing-block / writeback bundle for pb_exec_ctrl.
// master = instruction source and result sink, slave = controller.
interface pb_exec_ctrl_if #(
  parameter int TREE_DEPTH = 3,
  parameter int N_TREE     = 2,
  parameter int TAG_W      = 4
);
  localparam int N_ALU = 2**TREE_DEPTH - 1;
  localparam int MW    = N_TREE * N_ALU * 2;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [MW-1:0]    in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             pb_rd_en;
  logic             pb_en;
  logic [MW-1:0]    pb_alu_mode;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_mode, in_tag, wb_ready,
    input  in_ready, pb_rd_en, pb_en, pb_alu_mode,
    input  wb_valid, wb_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_mode, in_tag, wb_ready,
    output in_ready, pb_rd_en, pb_en, pb_alu_mode,
    output wb_valid, wb_tag, busy
  );
endinterface

// File: rtl/pb_exec_ctrl.sv
// Issue/skew/writeback controller for a block of ALU trees.
// Define PB_EXEC_CTRL_PERF_CNT_EN to add issue/stall counters.
module pb_exec_ctrl #(
  parameter int TREE_DEPTH = 3,
  parameter int N_TREE     = 2,
  parameter int TAG_W      = 4
) (
  input  logic clk,
  input  logic rst,
  pb_exec_ctrl_if.slave bus
`ifdef PB_EXEC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int D     = TREE_DEPTH;
  localparam int N_ALU = 2**TREE_DEPTH - 1;
  localparam int MW    = N_TREE * N_ALU * 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_STALL
  } state_t;

  // Heap index -> tree level (1 = leaves, D = top ALU).
  function automatic int alu_lvl(int a);
    int f;
    f = 0;
    for (int i = 1; i < 16; i++)
      if ((1 << i) <= a + 1) f = i;
    return D - f;
  endfunction

  logic             r_v    [D];
  logic [TAG_W-1:0] r_tag  [D];
  logic [MW-1:0]    r_mode [D-1];
  logic [MW-1:0]    r_mode_hold;
  state_t           r_state;

  logic          w_stall;
  logic          w_pb_en;
  logic          w_fire;
  logic          w_nxt_any;
  logic [MW-1:0] w_live;

  assign w_stall = r_v[D-1] & ~bus.wb_ready & ~rst;
  assign w_pb_en = ~w_stall;
  assign w_fire  = bus.in_valid & bus.in_ready;

  assign bus.in_ready    = ~w_stall & ~bus.flush & ~rst;
  assign bus.pb_rd_en    = w_fire;
  assign bus.pb_en       = w_pb_en;
  assign bus.wb_valid    = r_v[D-1];
  assign bus.wb_tag      = r_tag[D-1];
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.pb_alu_mode = w_stall ? r_mode_hold : w_live;

  // Level L works on the instruction issued L-1 enabled cycles ago.
  for (genvar t = 0; t < N_TREE; t++) begin : g_tree
    for (genvar a = 0; a < N_ALU; a++) begin : g_alu
      localparam int L = alu_lvl(a);
      localparam int B = (t * N_ALU + a) * 2;
      if (L == 1) begin : g_leaf
        assign w_live[B+:2] =
          w_fire ? bus.in_mode[B+:2] : 2'b11;
      end else begin : g_upper
        assign w_live[B+:2] =
          r_v[L-2] ? r_mode[L-2][B+:2] : 2'b11;
      end
    end
  end

  always_comb begin
    w_nxt_any = 1'b0;
    if (bus.flush) begin
      w_nxt_any = 1'b0;
    end else if (w_pb_en) begin
      w_nxt_any = w_fire;
      for (int k = 0; k < D - 1; k++)
        w_nxt_any = w_nxt_any | r_v[k];
    end else begin
      for (int k = 0; k < D; k++)
        w_nxt_any = w_nxt_any | r_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        r_v[k]   <= 1'b0;
        r_tag[k] <= '0;
      end
      for (int k = 0; k < D - 1; k++)
        r_mode[k] <= '1;
      r_mode_hold <= '1;
      r_state     <= S_IDLE;
    end else begin
      r_mode_hold <= bus.pb_alu_mode;
      if (bus.flush) begin
        for (int k = 0; k < D; k++)
          r_v[k] <= 1'b0;
      end else if (w_pb_en) begin
        r_v[0]   <= w_fire;
        r_tag[0] <= w_fire ? bus.in_tag : '0;
        r_mode[0] <= w_fire ? bus.in_mode : '1;
        for (int k = 1; k < D; k++) begin
          r_v[k]   <= r_v[k-1];
          r_tag[k] <= r_tag[k-1];
        end
        for (int k = 1; k < D - 1; k++)
          r_mode[k] <= r_mode[k-1];
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_nxt_any) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!w_nxt_any)   r_state <= S_IDLE;
          else if (w_stall) r_state <= S_STALL;
        end
        S_STALL: begin
          if (!w_nxt_any)    r_state <= S_IDLE;
          else if (!w_stall) r_state <= S_ACTIVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PB_EXEC_CTRL_PERF_CNT_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire && r_issue_cnt != '1)
        r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pb_exec_ctrl.sv
// Scoreboard bench for pb_exec_ctrl (TREE_DEPTH=3, N_TREE=2).
// Tags are queued at issue and popped on each writeback.
module tb_pb_exec_ctrl;
  localparam int D  = 3;
  localparam int NT = 2;
  localparam int TW = 4;
  localparam int NA = 7;
  localparam int MW = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pb_exec_ctrl_if #(
    .TREE_DEPTH(D), .N_TREE(NT), .TAG_W(TW)
  ) bus ();

`ifdef PB_EXEC_CTRL_PERF_CNT_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  pb_exec_ctrl #(
    .TREE_DEPTH(D), .N_TREE(NT), .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PB_EXEC_CTRL_PERF_CNT_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int n_ret = 0;
  logic [TW-1:0] sb_q [$];

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Expected mode vector: per-level field broadcast to all trees.
  function automatic logic [MW-1:0] mix(
    logic [1:0] l1, logic [1:0] l2, logic [1:0] l3);
    logic [MW-1:0] v;
    logic [1:0] f;
    v = '0;
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < NA; a++) begin
        f = (a == 0) ? l3 : ((a <= 2) ? l2 : l1);
        v[(t*NA+a)*2 +: 2] = f;
      end
    return v;
  endfunction

  function automatic logic [MW-1:0] bcast(logic [1:0] c);
    return mix(c, c, c);
  endfunction

  function automatic logic [1:0] code_of(int tag);
    return 2'(tag % 3);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.wb_valid && bus.wb_ready) begin
      n_ret++;
      if (sb_q.size() == 0)
        chk("wb_spurious", 64'(bus.wb_valid), 64'd0);
      else
        chk("wb_tag", 64'(bus.wb_tag), 64'(sb_q.pop_front()));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_tag = '0;
    bus.in_mode = '0;
    bus.wb_ready = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  int nxt;
  int r0;
  logic acc;

  initial begin
    // Reset values, with an instruction offered during reset
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_tag = 4'd9;
    bus.in_mode = '0;
    bus.wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_rd_en", 64'(bus.pb_rd_en), 0);
    chk("rst_pb_en", 64'(bus.pb_en), 1);
    chk("rst_wb_valid", 64'(bus.wb_valid), 0);
    chk("rst_wb_tag", 64'(bus.wb_tag), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_mode", 64'(bus.pb_alu_mode), 64'(bcast(2'd3)));

    // Single instruction, tag 5, PROD everywhere
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cyc_start();
      bus.in_valid = (c == 0);
      bus.in_tag = 4'd5;
      bus.in_mode = bcast(2'd1);
      @(negedge clk);
      if (c == 0) begin
        sb_q.push_back(4'd5);
        chk("s_rd_en", 64'(bus.pb_rd_en), 1);
        chk("s_mode0", 64'(bus.pb_alu_mode),
            64'(mix(2'd1, 2'd3, 2'd3)));
      end
      if (c == 1) begin
        chk("s_mode1", 64'(bus.pb_alu_mode),
            64'(mix(2'd3, 2'd1, 2'd3)));
        chk("s_busy1", 64'(bus.busy), 1);
      end
      if (c == 2)
        chk("s_mode2", 64'(bus.pb_alu_mode),
            64'(mix(2'd3, 2'd3, 2'd1)));
      chk("s_wb_valid", 64'(bus.wb_valid), 64'(c == 3));
      if (c == 4) chk("s_busy4", 64'(bus.busy), 0);
    end

    // Four back-to-back issues
    do_reset();
    r0 = n_ret;
    for (int c = 0; c < 9; c++) begin
      cyc_start();
      bus.in_valid = (c < 4);
      bus.in_tag = 4'(c + 1);
      bus.in_mode = bcast(code_of(c + 1));
      @(negedge clk);
      if (c < 4) begin
        chk("b_in_ready", 64'(bus.in_ready), 1);
        sb_q.push_back(4'(c + 1));
      end
      chk("b_wb_valid", 64'(bus.wb_valid),
          64'(c >= 3 && c <= 6));
      if (c == 4)
        chk("b_mode4", 64'(bus.pb_alu_mode),
            64'(mix(2'd3, code_of(4), code_of(3))));
      if (c == 7)
        chk("b_idle_mode", 64'(bus.pb_alu_mode),
            64'(bcast(2'd3)));
    end
    chk("b_retired", 64'(n_ret - r0), 4);

    // Stream with writeback backpressure in cycles 3..5
    do_reset();
    r0 = n_ret;
    nxt = 1;
    for (int c = 0; c < 13; c++) begin
      cyc_start();
      bus.wb_ready = !(c >= 3 && c <= 5);
      bus.in_valid = (nxt <= 4);
      bus.in_tag = 4'(nxt);
      bus.in_mode = bcast(code_of(nxt));
      @(negedge clk);
      acc = !(c >= 3 && c <= 5);
      if (bus.in_valid) begin
        chk("st_in_ready", 64'(bus.in_ready), 64'(acc));
        if (acc) begin
          sb_q.push_back(4'(nxt));
          nxt++;
        end
      end
      if (c >= 3 && c <= 5) begin
        chk("st_pb_en", 64'(bus.pb_en), 0);
        chk("st_wb_tag", 64'(bus.wb_tag), 1);
        chk("st_busy", 64'(bus.busy), 1);
        chk("st_mode_hold", 64'(bus.pb_alu_mode),
            64'(mix(code_of(3), code_of(2), code_of(1))));
      end
      if (c == 6) chk("st_pb_en6", 64'(bus.pb_en), 1);
    end
    bus.wb_ready = 1'b1;
    chk("st_retired", 64'(n_ret - r0), 4);
`ifdef PB_EXEC_CTRL_PERF_CNT_EN
    chk("perf_issue", 64'(perf_issue_cnt), 4);
    chk("perf_stall", 64'(perf_stall_cnt), 3);
`endif

    // Flush with two in flight and a concurrent offer
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc_start();
      bus.flush = (c == 2);
      bus.in_valid = (c <= 2);
      bus.in_tag = 4'(7 + c);
      bus.in_mode = bcast(2'd0);
      if (c == 2) sb_q.delete();
      @(negedge clk);
      if (c < 2) sb_q.push_back(4'(7 + c));
      if (c == 2) begin
        chk("f_in_ready", 64'(bus.in_ready), 0);
        chk("f_rd_en", 64'(bus.pb_rd_en), 0);
      end
      if (c == 3) chk("f_busy", 64'(bus.busy), 0);
      if (c >= 3) chk("f_wb_valid", 64'(bus.wb_valid), 0);
    end

    // Reset with one instruction in flight
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cyc_start();
      rst = (c == 1);
      bus.in_valid = (c == 0);
      bus.in_tag = 4'd6;
      bus.in_mode = bcast(2'd2);
      if (c == 1) sb_q.delete();
      @(negedge clk);
      if (c == 0) sb_q.push_back(4'd6);
      if (c == 2) begin
        chk("r_busy", 64'(bus.busy), 0);
        chk("r_wb_tag", 64'(bus.wb_tag), 0);
        chk("r_pb_en", 64'(bus.pb_en), 1);
        chk("r_mode", 64'(bus.pb_alu_mode),
            64'(bcast(2'd3)));
      end
      if (c >= 2) chk("r_wb_valid", 64'(bus.wb_valid), 0);
    end

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
